// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the addi/bne datapath.
// Owns the instruction register, the imem handshake and the datapath control strobes.
module multicycle_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr,
  input  logic             EQ,
  output logic [2:0]       ALUctrl,
  output logic             RegWrite,
  output logic             ALUsrc,
  output logic [1:0]       ImmSrc,
  output logic             PCsrc,
  output logic             PCWrite,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             fetch_timeout,
  output logic [31:0]      retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] instr_q;
  logic [7:0]       wait_cnt;
  logic             illegal_q, timeout_q;
  logic [31:0]      retired_q;

  logic is_addi, is_bne, timeout_hit, retire;

  assign is_addi     = (instr_q[6:0] == 7'd19) && (instr_q[14:12] == 3'b000);
  assign is_bne      = (instr_q[6:0] == 7'd99) && (instr_q[14:12] == 3'b001);
  assign timeout_hit = (state_q == S_FETCH) && !imem_ack && (wait_cnt == WAIT_LAST);
  assign retire      = ((state_q == S_EXEC) && is_bne) || (state_q == S_WB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack)         state_d = S_DECODE;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_DECODE: state_d = (is_addi || is_bne) ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_bne) state_d = run ? S_FETCH : S_IDLE;
        else        state_d = S_WB;
      end
      S_WB:     state_d = run ? S_FETCH : S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    RegWrite = 1'b0;
    PCWrite  = 1'b0;
    PCsrc    = 1'b0;
    ALUctrl  = 3'b111;
    ALUsrc   = 1'b1;
    ImmSrc   = 2'b11;
    case (state_q)
      S_FETCH: imem_req = 1'b1;
      S_EXEC: begin
        if (is_bne) begin
          ALUctrl = 3'b001;
          ALUsrc  = 1'b0;
          PCWrite = 1'b1;
          PCsrc   = !EQ;
        end else begin
          ALUctrl = 3'b000;
          ImmSrc  = 2'b00;
        end
      end
      S_WB: begin
        ALUctrl  = 3'b000;
        ImmSrc   = 2'b00;
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  // Instruction register, fetch wait counter, sticky flags and retire count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= '0;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      if (state_q == S_FETCH) begin
        if (imem_ack) begin
          instr_q  <= imem_rdata;
          wait_cnt <= '0;
        end else if (timeout_hit) begin
          wait_cnt  <= '0;
          timeout_q <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end
      if ((state_q == S_DECODE) && !(is_addi || is_bne)) illegal_q <= 1'b1;
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

  assign state         = state_q;
  assign instr         = instr_q;
  assign illegal       = illegal_q;
  assign fetch_timeout = timeout_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed + randomized bench for multicycle_ctrl; expectations come from an instruction-level model.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst, run, imem_ack, EQ;
  logic [31:0] imem_rdata;
  logic        imem_req, RegWrite, ALUsrc, PCsrc, PCWrite, illegal, fetch_timeout;
  logic [31:0] instr, retired;
  logic [2:0]  ALUctrl, state;
  logic [1:0]  ImmSrc;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_retired;
  logic [31:0] prev_instr;

  multicycle_ctrl #(.WIDTH(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .EQ(EQ), .ALUctrl(ALUctrl), .RegWrite(RegWrite),
    .ALUsrc(ALUsrc), .ImmSrc(ImmSrc), .PCsrc(PCsrc), .PCWrite(PCWrite),
    .state(state), .illegal(illegal), .fetch_timeout(fetch_timeout),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_addi();
    logic [31:0] r;
    r = $urandom;
    return {r[31:15], 3'b000, r[11:7], 7'd19};
  endfunction

  function automatic logic [31:0] rand_bne();
    logic [31:0] r;
    r = $urandom;
    return {r[31:15], 3'b001, r[11:7], 7'd99};
  endfunction

  task automatic check_defaults(input string tag);
    chk({tag, "_ctl"}, {26'd0, ALUctrl, ALUsrc, ImmSrc}, {26'd0, 3'b111, 1'b1, 2'b11});
    chk({tag, "_en"}, {28'd0, imem_req, RegWrite, PCWrite, PCsrc}, 32'd0);
  endtask

  // Called at a falling edge while in FETCH; d = wait cycles before ack.
  task automatic run_instr(input logic [31:0] word, input int d, input logic run_after);
    logic bne_op;
    logic eq;
    bne_op = (word[6:0] == 7'd99);
    for (int k = 0; k <= d; k++) begin
      imem_ack   = (k == d);
      imem_rdata = (k == d) ? word : $urandom;
      #1;
      chk("fetch_state", {29'd0, state}, 32'd1);
      chk("fetch_req", {31'd0, imem_req}, 32'd1);
      chk("fetch_instr_hold", instr, prev_instr);
      chk("fetch_en", {30'd0, RegWrite, PCWrite}, 32'd0);
      @(negedge clk);
    end
    imem_ack = 1'b0;
    run      = run_after;
    #1;
    chk("dec_state", {29'd0, state}, 32'd2);
    chk("dec_instr", instr, word);
    chk("dec_en", {29'd0, RegWrite, PCWrite, imem_req}, 32'd0);
    prev_instr = word;
    @(negedge clk);
    eq = 1'($urandom);
    EQ = eq;
    #1;
    chk("exec_state", {29'd0, state}, 32'd3);
    if (bne_op) begin
      chk("exec_bne_ctl", {26'd0, ALUctrl, ALUsrc, ImmSrc}, {26'd0, 3'b001, 1'b0, 2'b11});
      chk("exec_bne_en", {29'd0, RegWrite, PCWrite, PCsrc}, {29'd0, 1'b0, 1'b1, !eq});
      model_retired = model_retired + 32'd1;
    end else begin
      chk("exec_addi_ctl", {26'd0, ALUctrl, ALUsrc, ImmSrc}, {26'd0, 3'b000, 1'b1, 2'b00});
      chk("exec_addi_en", {30'd0, RegWrite, PCWrite}, 32'd0);
      @(negedge clk);
      #1;
      chk("wb_state", {29'd0, state}, 32'd4);
      chk("wb_ctl", {26'd0, ALUctrl, ALUsrc, ImmSrc}, {26'd0, 3'b000, 1'b1, 2'b00});
      chk("wb_en", {29'd0, RegWrite, PCWrite, PCsrc}, {29'd0, 1'b1, 1'b1, 1'b0});
      model_retired = model_retired + 32'd1;
    end
    @(negedge clk);
    chk("retired", retired, model_retired);
    chk("after_state", {29'd0, state}, run_after ? 32'd1 : 32'd0);
  endtask

  task automatic reset_and_check(input string tag);
    rst = 1'b1;
    #1;
    model_retired = '0;
    prev_instr    = '0;
    chk({tag, "_state"}, {29'd0, state}, 32'd0);
    chk({tag, "_regs"}, instr | retired, 32'd0);
    chk({tag, "_flags"}, {30'd0, illegal, fetch_timeout}, 32'd0);
    check_defaults(tag);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0; EQ = 1'b0;
    model_retired = '0; prev_instr = '0;
    repeat (2) @(negedge clk);
    reset_and_check("reset");
    @(negedge clk);
    chk("idle_hold", {29'd0, state}, 32'd0);

    // Directed addi with zero-wait fetch, then a random instruction stream
    run = 1'b1;
    @(negedge clk);
    run_instr(32'h00500093, 0, 1'b1);
    for (int i = 0; i < 24; i++) begin
      logic keep;
      keep = ($urandom_range(0, 3) != 0);
      run_instr(($urandom_range(0, 1) == 1) ? rand_bne() : rand_addi(),
                int'($urandom_range(0, 5)), keep);
      if (!keep) begin
        @(negedge clk);
        chk("idle_wait", {29'd0, state}, 32'd0);
        run = 1'b1;
        @(negedge clk);
        chk("idle_to_fetch", {29'd0, state}, 32'd1);
      end
    end

    // Fetch timeout: 15 unacknowledged FETCH cycles then HALT
    imem_ack = 1'b0;
    for (int k = 0; k < 15; k++) begin
      chk("to_state", {29'd0, state}, 32'd1);
      chk("to_req", {31'd0, imem_req}, 32'd1);
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      chk("to_halt", {29'd0, state}, 32'd5);
      chk("to_flags", {30'd0, illegal, fetch_timeout}, 32'd1);
      check_defaults("to_halt");
      @(negedge clk);
    end

    // Unsupported opcode
    reset_and_check("reset2");
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'h00000033;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("ill_dec", {29'd0, state}, 32'd2);
    chk("ill_dec_flag", {31'd0, illegal}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("ill_halt", {29'd0, state}, 32'd5);
      chk("ill_flags", {30'd0, illegal, fetch_timeout}, 32'd2);
      check_defaults("ill_halt");
    end

    // Asynchronous reset in the middle of an EXEC cycle
    reset_and_check("reset3");
    @(negedge clk);
    run_instr(rand_addi(), 1, 1'b1);
    imem_ack = 1'b1; imem_rdata = rand_bne();
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    EQ = 1'b0;
    #1;
    chk("pre_rst_exec", {29'd0, state}, 32'd3);
    chk("pre_rst_pcw", {31'd0, PCWrite}, 32'd1);
    #1;
    reset_and_check("async_rst");

    // retired wrap from all-ones to zero
    @(negedge clk);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    model_retired = 32'hFFFF_FFFF;
    chk("preload", retired, 32'hFFFF_FFFF);
    run_instr(rand_bne(), 0, 1'b1);
    chk("wrap_zero", retired, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
